// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/capture sequencer between EXE and the signed/unsigned divider cores
module div_issue_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic        req_signed,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic        req_ready,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_quot,
  output logic [31:0] resp_rem,
  output logic        busy,
  output logic [31:0] dividend_tdata,
  output logic [31:0] divisor_tdata,
  output logic        s_dividend_tvalid,
  output logic        s_divisor_tvalid,
  input  logic        s_dividend_tready,
  input  logic        s_divisor_tready,
  input  logic        s_dout_tvalid,
  input  logic [63:0] s_dout_tdata,
  output logic        u_dividend_tvalid,
  output logic        u_divisor_tvalid,
  input  logic        u_dividend_tready,
  input  logic        u_divisor_tready,
  input  logic        u_dout_tvalid,
  input  logic [63:0] u_dout_tdata
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT, DONE, DRAIN} state_t;

  state_t      state_q, state_d;
  logic        sel_signed_q, sel_signed_d;
  logic        dvd_sent_q, dvd_sent_d;
  logic        dvs_sent_q, dvs_sent_d;
  logic        cancel_q, cancel_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;

  logic        dvd_tvalid, dvs_tvalid;
  logic        dvd_tready, dvs_tready;
  logic        dout_tvalid;
  logic [63:0] dout_tdata;

  // Channel valids are pure state decodes, so they cannot drop before their handshake
  assign dvd_tvalid = (state_q == SEND) && !dvd_sent_q;
  assign dvs_tvalid = (state_q == SEND) && !dvs_sent_q;

  assign s_dividend_tvalid = dvd_tvalid && sel_signed_q;
  assign s_divisor_tvalid  = dvs_tvalid && sel_signed_q;
  assign u_dividend_tvalid = dvd_tvalid && !sel_signed_q;
  assign u_divisor_tvalid  = dvs_tvalid && !sel_signed_q;

  // Only the selected core's readies and result pulse are ever looked at
  assign dvd_tready  = sel_signed_q ? s_dividend_tready : u_dividend_tready;
  assign dvs_tready  = sel_signed_q ? s_divisor_tready  : u_divisor_tready;
  assign dout_tvalid = sel_signed_q ? s_dout_tvalid     : u_dout_tvalid;
  assign dout_tdata  = sel_signed_q ? s_dout_tdata      : u_dout_tdata;

  assign req_ready      = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign resp_valid     = (state_q == DONE);
  assign resp_quot      = quot_q;
  assign resp_rem       = rem_q;
  assign dividend_tdata = dividend_q;
  assign divisor_tdata  = divisor_q;

  // Next-state and datapath-latch computation for the issue/capture sequence
  always_comb begin
    state_d      = state_q;
    sel_signed_d = sel_signed_q;
    dvd_sent_d   = dvd_sent_q;
    dvs_sent_d   = dvs_sent_q;
    cancel_d     = cancel_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          dividend_d   = req_dividend;
          divisor_d    = req_divisor;
          sel_signed_d = req_signed;
          dvd_sent_d   = 1'b0;
          dvs_sent_d   = 1'b0;
          cancel_d     = 1'b0;
          state_d      = SEND;
        end
      end
      SEND: begin
        dvd_sent_d = dvd_sent_q || (dvd_tvalid && dvd_tready);
        dvs_sent_d = dvs_sent_q || (dvs_tvalid && dvs_tready);
        // A flush cannot retract an offered operand, so remember it and drain later
        cancel_d   = cancel_q || flush;
        if (dvd_sent_d && dvs_sent_d) begin
          state_d = cancel_d ? DRAIN : WAIT;
        end
      end
      WAIT: begin
        if (dout_tvalid && flush) begin
          state_d = IDLE;
        end else if (dout_tvalid) begin
          quot_d  = dout_tdata[63:32];
          rem_d   = dout_tdata[31:0];
          state_d = DONE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        if (flush || resp_ready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (dout_tvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers; reset also aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      sel_signed_q <= 1'b0;
      dvd_sent_q   <= 1'b0;
      dvs_sent_q   <= 1'b0;
      cancel_q     <= 1'b0;
      dividend_q   <= 32'd0;
      divisor_q    <= 32'd0;
      quot_q       <= 32'd0;
      rem_q        <= 32'd0;
    end else begin
      state_q      <= state_d;
      sel_signed_q <= sel_signed_d;
      dvd_sent_q   <= dvd_sent_d;
      dvs_sent_q   <= dvs_sent_d;
      cancel_q     <= cancel_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - scoreboard bench for div_issue_ctrl
module tb_div_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        req_ready;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_quot;
  logic [31:0] resp_rem;
  logic        busy;
  logic [31:0] dividend_tdata;
  logic [31:0] divisor_tdata;
  logic        s_dividend_tvalid, s_divisor_tvalid;
  logic        s_dividend_tready, s_divisor_tready;
  logic        s_dout_tvalid;
  logic [63:0] s_dout_tdata;
  logic        u_dividend_tvalid, u_divisor_tvalid;
  logic        u_dividend_tready, u_divisor_tready;
  logic        u_dout_tvalid;
  logic [63:0] u_dout_tdata;

  int unsigned vectors;
  int unsigned miscompares;
  logic [63:0] exp_q[$];

  div_issue_ctrl dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_signed        (req_signed),
    .req_dividend      (req_dividend),
    .req_divisor       (req_divisor),
    .req_ready         (req_ready),
    .flush             (flush),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_quot         (resp_quot),
    .resp_rem          (resp_rem),
    .busy              (busy),
    .dividend_tdata    (dividend_tdata),
    .divisor_tdata     (divisor_tdata),
    .s_dividend_tvalid (s_dividend_tvalid),
    .s_divisor_tvalid  (s_divisor_tvalid),
    .s_dividend_tready (s_dividend_tready),
    .s_divisor_tready  (s_divisor_tready),
    .s_dout_tvalid     (s_dout_tvalid),
    .s_dout_tdata      (s_dout_tdata),
    .u_dividend_tvalid (u_dividend_tvalid),
    .u_divisor_tvalid  (u_divisor_tvalid),
    .u_dividend_tready (u_dividend_tready),
    .u_divisor_tready  (u_divisor_tready),
    .u_dout_tvalid     (u_dout_tvalid),
    .u_dout_tdata      (u_dout_tdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural core: {quot, rem} with truncating division
  function automatic logic [63:0] core_res(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    if (sgn) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic chk_tv(input string tag, input logic [3:0] exp);
    check(tag, {60'd0, s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}, {60'd0, exp});
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_resp_valid"}, resp_valid, 0);
    chk_tv({tag, "_tvalids"}, 4'b0000);
  endtask

  task automatic check_resp(input string tag);
    logic [63:0] e;
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_resp_valid"}, resp_valid, 1);
      check({tag, "_quot"}, resp_quot, e[63:32]);
      check({tag, "_rem"}, resp_rem, e[31:0]);
    end
  endtask

  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    req_valid    = 1'b1;
    req_signed   = sgn;
    req_dividend = a;
    req_divisor  = b;
  endtask

  initial begin
    logic [63:0] e;
    vectors      = 0;
    miscompares  = 0;
    resetn       = 1'b0;
    req_valid    = 1'b0;
    req_signed   = 1'b0;
    req_dividend = 32'd0;
    req_divisor  = 32'd0;
    flush        = 1'b0;
    resp_ready   = 1'b0;
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    s_dout_tvalid     = 1'b0;
    s_dout_tdata      = 64'd0;
    u_dividend_tready = 1'b0;
    u_divisor_tready  = 1'b0;
    u_dout_tvalid     = 1'b0;
    u_dout_tdata      = 64'd0;

    repeat (3) step();
    chk_idle("rst");
    check("rst_quot", resp_quot, 0);
    check("rst_rem", resp_rem, 0);
    check("rst_dvd_tdata", dividend_tdata, 0);
    check("rst_dvs_tdata", divisor_tdata, 0);
    resetn = 1'b1;
    step();

    // Signed -7 / 2, readies high, core pulse at T+6
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    s_dividend_tready = 1'b1;
    s_divisor_tready  = 1'b1;
    exp_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
    check("t1_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    check("t1_busy", busy, 1);
    chk_tv("t1_send_tv", 4'b1100);
    check("t1_dvd_tdata", dividend_tdata, 32'hFFFF_FFF9);
    check("t1_dvs_tdata", divisor_tdata, 32'd2);
    step();
    chk_tv("t1_wait_tv", 4'b0000);
    check("t1_wait_busy", busy, 1);
    repeat (4) step();
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = core_res(1'b1, 32'hFFFF_FFF9, 32'd2);
    check("t1_pre_resp", resp_valid, 0);
    step();
    s_dout_tvalid = 1'b0;
    s_dout_tdata  = 64'd0;
    check_resp("t1");
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk_idle("t1_end");

    // Unsigned 0xFFFFFFFF / 16 with staggered readies
    issue(1'b0, 32'hFFFF_FFFF, 32'd16);
    u_dividend_tready = 1'b0;
    u_divisor_tready  = 1'b0;
    exp_q.push_back({32'h0FFF_FFFF, 32'h0000_000F});
    step();
    req_valid = 1'b0;
    chk_tv("t2_t1_tv", 4'b0011);
    step();
    chk_tv("t2_t2_tv", 4'b0011);
    u_dividend_tready = 1'b1;
    step();
    u_dividend_tready = 1'b0;
    chk_tv("t2_t3_tv", 4'b0001);
    step();
    chk_tv("t2_t4_tv", 4'b0001);
    check("t2_t4_dvs_tdata", divisor_tdata, 32'd16);
    u_divisor_tready = 1'b1;
    step();
    u_divisor_tready = 1'b0;
    chk_tv("t2_t5_tv", 4'b0000);
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
    step();
    s_dout_tvalid = 1'b0;
    check("t2_other_core_ignored", resp_valid, 0);
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = core_res(1'b0, 32'hFFFF_FFFF, 32'd16);
    step();
    u_dout_tvalid = 1'b0;
    check_resp("t2");
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk_idle("t2_end");

    // Flush in SEND with the divisor still pending
    issue(1'b1, 32'd50, 32'd5);
    s_divisor_tready = 1'b0;
    step();
    req_valid = 1'b0;
    chk_tv("t3_t1_tv", 4'b1100);
    step();
    chk_tv("t3_t2_tv", 4'b0100);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_tv("t3_t3_tv", 4'b0100);
    s_divisor_tready = 1'b1;
    step();
    chk_tv("t3_drain_tv", 4'b0000);
    check("t3_drain_busy", busy, 1);
    check("t3_drain_req_ready", req_ready, 0);
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = core_res(1'b1, 32'd50, 32'd5);
    step();
    s_dout_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_idle($sformatf("t3_swallow%0d", i));
      step();
    end

    // Flush in WAIT, stale pulse drained, then 100 / 7
    issue(1'b0, 32'd9, 32'd3);
    u_dividend_tready = 1'b1;
    u_divisor_tready  = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_drain_busy", busy, 1);
    check("t4_drain_req_ready", req_ready, 0);
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = core_res(1'b0, 32'd9, 32'd3);
    step();
    u_dout_tvalid = 1'b0;
    check("t4_after_drain_resp", resp_valid, 0);
    check("t4_after_drain_ready", req_ready, 1);
    issue(1'b0, 32'd100, 32'd7);
    exp_q.push_back({32'd14, 32'd2});
    step();
    req_valid = 1'b0;
    check("t4_dvd_tdata", dividend_tdata, 32'd100);
    step();
    step();
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = core_res(1'b0, 32'd100, 32'd7);
    step();
    u_dout_tvalid = 1'b0;
    check_resp("t4");
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk_idle("t4_end");

    // Stall four cycles in DONE, then flush together with resp_ready
    issue(1'b1, 32'd100, 32'hFFFF_FFF9);
    exp_q.push_back({32'hFFFF_FFF2, 32'd2});
    step();
    req_valid = 1'b0;
    step();
    s_dout_tvalid = 1'b1;
    s_dout_tdata  = core_res(1'b1, 32'd100, 32'hFFFF_FFF9);
    step();
    s_dout_tvalid = 1'b0;
    s_dout_tdata  = 64'd0;
    e = exp_q[0];
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_stall%0d_valid", i), resp_valid, 1);
      check($sformatf("t5_stall%0d_quot", i), resp_quot, e[63:32]);
      check($sformatf("t5_stall%0d_rem", i), resp_rem, e[31:0]);
      step();
    end
    check("t5_still_valid", resp_valid, 1);
    flush      = 1'b1;
    resp_ready = 1'b1;
    step();
    flush      = 1'b0;
    resp_ready = 1'b0;
    void'(exp_q.pop_front());
    chk_idle("t5_dropped");
    check("t5_sb_empty", exp_q.size(), 0);

    // Reset in the middle of SEND, then req_valid+flush coincidence
    issue(1'b1, 32'd77, 32'd3);
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    step();
    req_valid = 1'b0;
    chk_tv("t6_send_tv", 4'b1100);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk_idle("t6_reset");
    check("t6_dvd_tdata", dividend_tdata, 0);
    issue(1'b1, 32'd5, 32'd1);
    flush = 1'b1;
    step();
    req_valid = 1'b0;
    flush     = 1'b0;
    chk_idle("t6_flush_req");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
